// File: rtl/memory_arbiter_pkg.sv
// Shared port ids, default widths and the response owner tag for memory_arbiter.
package memory_arbiter_pkg;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Remembers which port owns the Ram read that returns next cycle.
  typedef struct packed {
    logic vld;
    logic port_id;
  } owner_tag_t;

endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way arbiter, round-robin or port-0-fixed; grant is combinational from requests.
// Grants are forced low during reset; last_grant tracks the most recent winner.
module rr_arbiter2
  import memory_arbiter_pkg::*;
#(
  parameter int FixedPriority = 0
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_o        = 2'b00;
    last_grant_d = last_grant_q;
    if (!reset_i) begin
      if (req_i == 2'b11) begin
        // On a tie the port that did not win last goes first, unless port 0 is fixed.
        if (FixedPriority != 0 || last_grant_q == PORT_DATA) begin
          gnt_o = 2'b01;
        end else begin
          gnt_o = 2'b10;
        end
      end else begin
        gnt_o = req_i;
      end
    end
    if (gnt_o[1]) begin
      last_grant_d = PORT_DATA;
    end else if (gnt_o[0]) begin
      last_grant_d = PORT_FETCH;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_q <= PORT_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-cycle Ram between fetch and data read ports; responses arrive one cycle after transfer.
// Requests are held off via ready; responses are never backpressured.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int AddressWidth  = DEFAULT_ADDR_WIDTH,
  parameter int DataWidth     = DEFAULT_DATA_WIDTH,
  parameter int FixedPriority = 0
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    req0_valid_i,
  input  logic [AddressWidth-1:0] req0_address_i,
  output logic                    req0_ready_o,
  output logic                    rsp0_valid_o,
  output logic [DataWidth-1:0]    rsp0_data_o,
  input  logic                    req1_valid_i,
  input  logic [AddressWidth-1:0] req1_address_i,
  output logic                    req1_ready_o,
  output logic                    rsp1_valid_o,
  output logic [DataWidth-1:0]    rsp1_data_o,
  output logic                    ram_read_enable_o,
  output logic [AddressWidth-1:0] ram_address_o,
  input  logic [DataWidth-1:0]    ram_data_i
);

  logic [1:0] gnt;
  owner_tag_t tag_q;
  owner_tag_t tag_d;

  rr_arbiter2 #(
    .FixedPriority(FixedPriority)
  ) u_rr_arbiter2 (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .req_i   ({req1_valid_i, req0_valid_i}),
    .gnt_o   (gnt)
  );

  always_comb begin
    req0_ready_o      = gnt[0];
    req1_ready_o      = gnt[1];
    ram_read_enable_o = |gnt;
    ram_address_o     = '0;
    if (gnt[0]) begin
      ram_address_o = req0_address_i;
    end else if (gnt[1]) begin
      ram_address_o = req1_address_i;
    end
    tag_d.vld     = |gnt;
    tag_d.port_id = gnt[1] ? PORT_DATA : PORT_FETCH;

    // Ram data is steered only to the tagged owner; the other port reads zero.
    rsp0_valid_o = tag_q.vld && (tag_q.port_id == PORT_FETCH);
    rsp1_valid_o = tag_q.vld && (tag_q.port_id == PORT_DATA);
    rsp0_data_o  = rsp0_valid_o ? ram_data_i : '0;
    rsp1_data_o  = rsp1_valid_o ? ram_data_i : '0;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: round-robin and fixed-priority instances share stimulus,
// each checked against a cycle-level reference model plus directed grant tables.
module tb_memory_arbiter;

  logic        clk;
  logic        rst;
  logic        r0v;
  logic [31:0] r0a;
  logic        r1v;
  logic [31:0] r1a;

  logic [1:0]  rdy0;
  logic [1:0]  rdy1;
  logic [1:0]  rv0;
  logic [1:0]  rv1;
  logic [1:0]  ram_re;
  logic [31:0] rd0   [2];
  logic [31:0] rd1   [2];
  logic [31:0] ram_a [2];
  logic [31:0] ram_d [2];

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b1;

  string lbl [2] = '{"rr", "fp"};

  // Reference model state, one per instance (0 = round-robin, 1 = fixed priority).
  int          last_m [2] = '{1, 1};
  bit          pend_v [2] = '{1'b0, 1'b0};
  int          pend_p [2] = '{0, 0};
  logic [31:0] pend_d [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter #(.FixedPriority(0)) u_dut_rr (
    .clock_i           (clk),
    .reset_i           (rst),
    .req0_valid_i      (r0v),
    .req0_address_i    (r0a),
    .req0_ready_o      (rdy0[0]),
    .rsp0_valid_o      (rv0[0]),
    .rsp0_data_o       (rd0[0]),
    .req1_valid_i      (r1v),
    .req1_address_i    (r1a),
    .req1_ready_o      (rdy1[0]),
    .rsp1_valid_o      (rv1[0]),
    .rsp1_data_o       (rd1[0]),
    .ram_read_enable_o (ram_re[0]),
    .ram_address_o     (ram_a[0]),
    .ram_data_i        (ram_d[0])
  );

  memory_arbiter #(.FixedPriority(1)) u_dut_fp (
    .clock_i           (clk),
    .reset_i           (rst),
    .req0_valid_i      (r0v),
    .req0_address_i    (r0a),
    .req0_ready_o      (rdy0[1]),
    .rsp0_valid_o      (rv0[1]),
    .rsp0_data_o       (rd0[1]),
    .req1_valid_i      (r1v),
    .req1_address_i    (r1a),
    .req1_ready_o      (rdy1[1]),
    .rsp1_valid_o      (rv1[1]),
    .rsp1_data_o       (rd1[1]),
    .ram_read_enable_o (ram_re[1]),
    .ram_address_o     (ram_a[1]),
    .ram_data_i        (ram_d[1])
  );

  // Ram contents: word at address a is a + 3; idle cycles return a poison value.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ram_d[k] <= ram_re[k] ? ram_a[k] + 32'd3 : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int          win;
    logic [31:0] wa;
    win = -1;
    wa  = 32'd0;
    if (rst) begin
      chk({lbl[k], " rst rdy0"}, 64'(rdy0[k]), 64'd0);
      chk({lbl[k], " rst rdy1"}, 64'(rdy1[k]), 64'd0);
      chk({lbl[k], " rst ram_re"}, 64'(ram_re[k]), 64'd0);
      chk({lbl[k], " rst ram_a"}, 64'(ram_a[k]), 64'd0);
      chk({lbl[k], " rst rsp"}, {rv0[k], rv1[k], rd0[k] | rd1[k]}, 64'd0);
      last_m[k] = 1;
      pend_v[k] = 1'b0;
      return;
    end
    if (r0v && r1v) win = (k == 1) ? 0 : 1 - last_m[k];
    else if (r0v) win = 0;
    else if (r1v) win = 1;
    if (win == 0) wa = r0a;
    if (win == 1) wa = r1a;
    chk({lbl[k], " rdy0"}, 64'(rdy0[k]), 64'(win == 0));
    chk({lbl[k], " rdy1"}, 64'(rdy1[k]), 64'(win == 1));
    chk({lbl[k], " one_ready"}, 64'(rdy0[k] & rdy1[k]), 64'd0);
    chk({lbl[k], " ram_re"}, 64'(ram_re[k]), 64'(win >= 0));
    chk({lbl[k], " ram_a"}, 64'(ram_a[k]), 64'(wa));
    chk({lbl[k], " rsp0_v"}, 64'(rv0[k]), 64'(pend_v[k] && pend_p[k] == 0));
    chk({lbl[k], " rsp1_v"}, 64'(rv1[k]), 64'(pend_v[k] && pend_p[k] == 1));
    chk({lbl[k], " rsp0_d"}, 64'(rd0[k]), (pend_v[k] && pend_p[k] == 0) ? 64'(pend_d[k]) : 64'd0);
    chk({lbl[k], " rsp1_d"}, 64'(rd1[k]), (pend_v[k] && pend_p[k] == 1) ? 64'(pend_d[k]) : 64'd0);
    if (win >= 0) begin
      last_m[k] = win;
      pend_v[k] = 1'b1;
      pend_p[k] = win;
      pend_d[k] = wa + 32'd3;
    end else begin
      pend_v[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // Directed grant table: g_rr / g_fp give the expected winner (2 = nobody).
  typedef struct {
    logic        r0v;
    logic [31:0] r0a;
    logic        r1v;
    logic [31:0] r1a;
    int          g_rr;
    int          g_fp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1'b1, 32'h10, 1'b0, 32'h0,  0, 0};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 32'h0,  2, 2};
    vecs[2]  = '{1'b1, 32'h0,  1'b1, 32'h40, 1, 0};
    vecs[3]  = '{1'b1, 32'h0,  1'b1, 32'h40, 0, 0};
    vecs[4]  = '{1'b1, 32'h0,  1'b1, 32'h40, 1, 0};
    vecs[5]  = '{1'b1, 32'h0,  1'b1, 32'h40, 0, 0};
    vecs[6]  = '{1'b1, 32'h0,  1'b1, 32'h80, 1, 0};
    vecs[7]  = '{1'b1, 32'h0,  1'b1, 32'h84, 0, 0};
    vecs[8]  = '{1'b1, 32'h0,  1'b1, 32'h84, 1, 0};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 32'h84, 1, 1};
    vecs[10] = '{1'b0, 32'h0,  1'b0, 32'h0,  2, 2};
    vecs[11] = '{1'b0, 32'h0,  1'b1, 32'hC,  1, 1};
    vecs[12] = '{1'b1, 32'h20, 1'b1, 32'h24, 0, 0};
    vecs[13] = '{1'b1, 32'h20, 1'b0, 32'h0,  0, 0};

    rst = 1'b1;
    r0v = 1'b0;
    r0a = 32'h0;
    r1v = 1'b0;
    r1a = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      r0v = vecs[i].r0v;
      r0a = vecs[i].r0a;
      r1v = vecs[i].r1v;
      r1a = vecs[i].r1a;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int          g;
        logic [31:0] ea;
        g  = (k == 0) ? vecs[i].g_rr : vecs[i].g_fp;
        ea = (g == 0) ? vecs[i].r0a : (g == 1) ? vecs[i].r1a : 32'h0;
        chk($sformatf("tbl%0d %s rdy0", i, lbl[k]), 64'(rdy0[k]), 64'(g == 0));
        chk($sformatf("tbl%0d %s rdy1", i, lbl[k]), 64'(rdy1[k]), 64'(g == 1));
        chk($sformatf("tbl%0d %s ram_a", i, lbl[k]), 64'(ram_a[k]), 64'(ea));
      end
      if (i == 1) begin
        chk("first rsp0_v", 64'(rv0[0]), 64'd1);
        chk("first rsp0_d", 64'(rd0[0]), 64'h13);
        chk("first rsp1_v", 64'(rv1[0]), 64'd0);
      end
      @(posedge clk);
      #1;
    end

    // Reset right after a port 0 transfer: the pending response must vanish.
    r0v = 1'b1;
    r0a = 32'h30;
    r1v = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    r0v = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk({lbl[k], " async rsp0_v"}, 64'(rv0[k]), 64'd0);
      chk({lbl[k], " async rsp0_d"}, 64'(rd0[k]), 64'd0);
      chk({lbl[k], " async ram_a"}, 64'(ram_a[k]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk({lbl[k], " post-rst rsp0_v"}, 64'(rv0[k]), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic, addresses free to change while waiting.
    for (int c = 0; c < 1000; c++) begin
      r0v = ($urandom_range(0, 3) != 0);
      r1v = ($urandom_range(0, 3) != 0);
      r0a = $urandom;
      r1a = $urandom;
      @(posedge clk);
      #1;
    end

    r0v = 1'b0;
    r1v = 1'b0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter AddressWidth, default 32, width of all address ports.
REQ-002 Parameter DataWidth, default 32, width of all data ports.
REQ-003 Parameter FixedPriority, default 0; 0 = round-robin, 1 = port 0 always wins.
REQ-004 clock_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 req0_valid_i  input  1  port 0 (instruction fetch) read request.
REQ-007 req0_address_i  input  AddressWidth  port 0 byte address.
REQ-008 req0_ready_o  output  1  port 0 request accepted this cycle.
REQ-009 rsp0_valid_o  output  1  port 0 read data valid (one-cycle pulse).
REQ-010 rsp0_data_o  output  DataWidth  port 0 read data.
REQ-011 req1_valid_i, req1_address_i, req1_ready_o, rsp1_valid_o, rsp1_data_o: port 1 (data load), same widths and meanings as port 0.
REQ-012 ram_read_enable_o  output  1  read strobe to the shared Ram.
REQ-013 ram_address_o  output  AddressWidth  address to the shared Ram.
REQ-014 ram_data_i  input  DataWidth  Ram read data, valid the cycle after ram_read_enable_o is sampled high.

Function
REQ-015 A request transfers in any cycle where reqN_valid_i and reqN_ready_o are both high.
REQ-016 At most one of req0_ready_o, req1_ready_o SHALL be high per cycle; ready is combinational from valid inputs and arbitration state.
REQ-017 ram_read_enable_o SHALL be high exactly when a transfer occurs; ram_address_o SHALL equal the winning address, else 0.
REQ-018 Single request: that port wins with ready high in the same cycle (zero added latency).
REQ-019 Both requesting, FixedPriority=0: port not granted most recently wins; last_grant register updates on every transfer.
REQ-020 Both requesting, FixedPriority=1: port 0 wins; port 1 waits until req0_valid_i low.
REQ-021 Response routing: a registered owner tag (valid + port id) captured at transfer SHALL steer ram_data_i to rspN_data_o with rspN_valid_o high for exactly one cycle, the cycle after the transfer.
REQ-022 Read latency request-transfer to response: exactly 1 cycle; back-to-back transfers every cycle SHALL be supported with no bubble.
REQ-023 Responses are not backpressured; requester must accept rspN data in the pulse cycle.
REQ-024 Non-selected rspN_data_o SHALL hold 0; rsp valids are mutually exclusive.
REQ-025 Requester holding valid without ready SHALL not have its address sampled; address may change freely until transfer.
REQ-026 Address is passed unmodified (no alignment check, no truncation).

Reset
REQ-027 While reset_i high: req0/1_ready_o = 0, ram_read_enable_o = 0, ram_address_o = 0, rsp0/1_valid_o = 0, rsp0/1_data_o = 0.
REQ-028 Reset values: owner tag invalid, last_grant = port 1 (port 0 wins the first tie).
REQ-029 Reset asserted mid-transfer: pending response SHALL be dropped; no rsp pulse after reset release.
REQ-030 First transfer possible in the first cycle after reset_i deasserts.

Structure
REQ-031 Shared package holds port id constants (PORT_FETCH = 0, PORT_DATA = 1) and default address/data widths.
REQ-032 One sub-module rr_arbiter2 (two-way round-robin with FixedPriority parameter, grant outputs, last_grant state); routing and tag logic stay in memory_arbiter.

Verification
REQ-033 Reset, then req0 valid addr 0x10, Ram word 0x00000013 -> req0_ready_o same cycle, rsp0_valid_o next cycle with 0x00000013, rsp1_valid_o stays 0.
REQ-034 Both valid continuously (0x0 / 0x40), FixedPriority=0 -> grants alternate 0,1,0,1; responses alternate port 0/port 1 with correct data, one per cycle.
REQ-035 Same stimulus, FixedPriority=1 -> port 0 granted every cycle, req1_ready_o never high until req0_valid_i drops, then port 1 granted next cycle.
REQ-036 req1 valid addr 0x80 held 3 cycles while port 0 wins (FixedPriority=1), address changed to 0x84 in cycle 2 -> Ram sees 0x84 at port 1 transfer only.
REQ-037 Assert reset_i the cycle after a port 0 transfer -> no rsp0_valid_o pulse; all outputs 0 immediately (asynchronous).
REQ-038 Scoreboard random valid traffic 1000 cycles -> every transfer yields exactly one response on the correct port, one cycle later, never two ready high together.
